jedro_1_mem_arbiter: RTL and testbench
======================================

JEDRO_1_MEM_ARBITER -- requirements
Module: jedro_1_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, shall set the width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 32, shall set the width of all data ports; byte enables shall be DATA_WIDTH/8 bits.
REQ-003 Parameter STARVE_LIMIT, default 4, shall set the maximum number of consecutive LSU grants while the IFU waits.
REQ-004 Clocking shall be one clock; reset shall be synchronous and active-high; no other clock or reset shall exist.
REQ-005 clk_i  in  1  sole clock; all state shall change on the rising edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 ifu_req_i  in  1  instruction fetch request (read only).
REQ-008 ifu_addr_i  in  ADDR_WIDTH  fetch address.
REQ-009 ifu_gnt_o  out  1  fetch request accepted this cycle.
REQ-010 ifu_rvalid_o  out  1  fetch data valid.
REQ-011 ifu_rdata_o  out  DATA_WIDTH  fetched instruction word.
REQ-012 lsu_req_i  in  1  load/store request.
REQ-013 lsu_we_i  in  1  1 = store, 0 = load.
REQ-014 lsu_be_i  in  DATA_WIDTH/8  store byte enables.
REQ-015 lsu_addr_i  in  ADDR_WIDTH  data address.
REQ-016 lsu_wdata_i  in  DATA_WIDTH  store data.
REQ-017 lsu_gnt_o  out  1  data request accepted this cycle.
REQ-018 lsu_rvalid_o  out  1  load data valid / store acknowledged.
REQ-019 lsu_rdata_o  out  DATA_WIDTH  load data.
REQ-020 mem_en_o  out  1  single-port memory access strobe.
REQ-021 mem_we_o  out  DATA_WIDTH/8  memory byte write enables.
REQ-022 mem_addr_o  out  ADDR_WIDTH  memory address.
REQ-023 mem_wdata_o  out  DATA_WIDTH  memory write data.
REQ-024 mem_rdata_i  in  DATA_WIDTH  memory read data, valid exactly one cycle after an enabled read.

Function
REQ-025 At most one of ifu_gnt_o/lsu_gnt_o shall be high per cycle; grants shall be combinational from requests and the starvation count.
REQ-026 Priority: LSU wins, except when starve_cnt == STARVE_LIMIT and ifu_req_i is high, then IFU wins.
REQ-027 starve_cnt shall increment (saturating at STARVE_LIMIT) on each LSU grant while ifu_req_i is high; it shall clear on an IFU grant or any cycle ifu_req_i is low.
REQ-028 On a grant, mem_en_o=1 and mem_addr_o/mem_we_o/mem_wdata_o shall mux from the winner in the same cycle; mem_we_o = lsu_be_i only for an LSU store, else 0.
REQ-029 With no grant, mem_en_o=0 and mem_we_o=0; mem_addr_o/mem_wdata_o are don't-care.
REQ-030 Owner register {NONE, IFU, LSU} shall load the winner (or NONE) every cycle.
REQ-031 Response latency shall be exactly 1 cycle: owner IFU -> ifu_rvalid_o=1; owner LSU -> lsu_rvalid_o=1 (for both loads and stores); owner NONE -> both 0.
REQ-032 ifu_rdata_o and lsu_rdata_o shall both be driven from mem_rdata_i; valid only with the matching rvalid.
REQ-033 Back-to-back grants shall be allowed every cycle (throughput 1 access/cycle); no bubble on owner switch.
REQ-034 Requesters shall hold req and payload until gnt; the arbiter shall not buffer requests.
REQ-035 Simultaneous requests with starve_cnt < STARVE_LIMIT shall grant LSU.

Reset
REQ-036 While rst_i is high: ifu_gnt_o=0, lsu_gnt_o=0, mem_en_o=0, mem_we_o=0 regardless of requests.
REQ-037 Rising edge with rst_i high shall set owner=NONE and starve_cnt=0, so both rvalid outputs are 0 the following cycle.
REQ-038 Reset mid-access shall drop the outstanding response; no rvalid shall be issued for it.

Structure
REQ-039 Package jedro_1_mem_arb_pkg shall hold the owner enum and default STARVE_LIMIT constant.
REQ-040 Grant and starvation logic shall be one sub-module, jedro_1_arb_prio; datapath muxing and owner register stay in the top.

Verification
REQ-041 IFU only, addr 0x0,0x4,0x8 on consecutive cycles -> gnt each cycle, ifu_rvalid_o one cycle later with ROM words 0,1,2.
REQ-042 Both request continuously, STARVE_LIMIT=4 -> grant pattern LSU,LSU,LSU,LSU,IFU repeating; never both grants.
REQ-043 LSU store addr 0x10, be 4'b0011, data 0xDEADBEEF, then load 0x10 -> mem_we_o=4'b0011 on store; load returns lower half 0xBEEF merged with prior upper half.
REQ-044 Alternating owner IFU->LSU->IFU on consecutive cycles -> each rvalid lands on the correct port with no data crossover.
REQ-045 rst_i asserted the cycle after an IFU grant -> no ifu_rvalid_o, grants 0 during reset, starve_cnt 0 after release.

Source files
------------

// File: rtl/jedro_1_mem_arbiter_pkg.sv
// Shared types and defaults for the jedro_1 instruction/data memory arbiter.
// Holds the response-owner encoding and the default starvation bound.
package jedro_1_mem_arb_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IFU  = 2'd1,
        OWNER_LSU  = 2'd2
    } owner_e;

    localparam int unsigned DEFAULT_STARVE_LIMIT = 4;

    // Counter width able to hold 0..limit; never narrower than one bit.
    function automatic int unsigned starve_cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/jedro_1_mem_arbiter_if.sv
// Bus bundle between the IFU, the LSU, the single-port memory and the arbiter.
// Signal suffixes are written from the arbiter's point of view.
interface jedro_1_mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                  ifu_req_i;
    logic [ADDR_WIDTH-1:0] ifu_addr_i;
    logic                  ifu_gnt_o;
    logic                  ifu_rvalid_o;
    logic [DATA_WIDTH-1:0] ifu_rdata_o;

    logic                  lsu_req_i;
    logic                  lsu_we_i;
    logic [BE_WIDTH-1:0]   lsu_be_i;
    logic [ADDR_WIDTH-1:0] lsu_addr_i;
    logic [DATA_WIDTH-1:0] lsu_wdata_i;
    logic                  lsu_gnt_o;
    logic                  lsu_rvalid_o;
    logic [DATA_WIDTH-1:0] lsu_rdata_o;

    logic                  mem_en_o;
    logic [BE_WIDTH-1:0]   mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  ifu_req_i, ifu_addr_i,
        output ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o,
        input  lsu_req_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
        output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output ifu_req_i, ifu_addr_i,
        input  ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o,
        output lsu_req_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
        input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );

endinterface

// File: rtl/jedro_1_mem_arbiter_prio.sv
// Grant selection between IFU and LSU: LSU has priority, but a waiting IFU
// is forced through after STARVE_LIMIT consecutive LSU grants.
module jedro_1_arb_prio
    import jedro_1_mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   ifu_req_i,
    input  logic   lsu_req_i,
    output logic   ifu_gnt_o,
    output logic   lsu_gnt_o,
    output owner_e winner_o
);

    localparam int unsigned CNT_W = starve_cnt_width(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_d;
    logic [CNT_W-1:0] starve_cnt_q;
    logic             ifu_wins;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= LIMIT) ? LIMIT : v + CNT_W'(1);
    endfunction

    always_comb begin
        ifu_wins  = ifu_req_i && (!lsu_req_i || (starve_cnt_q == LIMIT));
        ifu_gnt_o = !rst_i && ifu_wins;
        lsu_gnt_o = !rst_i && lsu_req_i && !ifu_wins;

        winner_o = OWNER_NONE;
        if (ifu_gnt_o) begin
            winner_o = OWNER_IFU;
        end else if (lsu_gnt_o) begin
            winner_o = OWNER_LSU;
        end

        // Only an LSU grant that overtakes a waiting IFU extends the run;
        // an IFU grant or an idle IFU ends it.
        starve_cnt_d = '0;
        if (ifu_req_i && lsu_gnt_o) begin
            starve_cnt_d = sat_inc(starve_cnt_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/jedro_1_mem_arbiter.sv
// Single-port memory arbiter for the jedro_1 core: muxes the winning request
// onto the memory and routes the one-cycle-late read data back to its owner.
module jedro_1_mem_arbiter
    import jedro_1_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input logic                  clk_i,
    input logic                  rst_i,
    jedro_1_mem_arbiter_if.slave bus
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                  ifu_gnt;
    logic                  lsu_gnt;
    owner_e                winner;
    owner_e                owner_d;
    owner_e                owner_q;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [BE_WIDTH-1:0]   mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;

    jedro_1_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ifu_req_i (bus.ifu_req_i),
        .lsu_req_i (bus.lsu_req_i),
        .ifu_gnt_o (ifu_gnt),
        .lsu_gnt_o (lsu_gnt),
        .winner_o  (winner)
    );

    always_comb begin
        mem_addr  = lsu_gnt ? bus.lsu_addr_i : bus.ifu_addr_i;
        mem_wdata = bus.lsu_wdata_i;
        mem_we    = (lsu_gnt && bus.lsu_we_i) ? bus.lsu_be_i : '0;
        owner_d   = winner;

        bus.ifu_gnt_o   = ifu_gnt;
        bus.lsu_gnt_o   = lsu_gnt;
        bus.mem_en_o    = ifu_gnt || lsu_gnt;
        bus.mem_we_o    = mem_we;
        bus.mem_addr_o  = mem_addr;
        bus.mem_wdata_o = mem_wdata;

        // Gating with rst_i drops a response whose access was cut by reset.
        bus.ifu_rvalid_o = !rst_i && (owner_q == OWNER_IFU);
        bus.lsu_rvalid_o = !rst_i && (owner_q == OWNER_LSU);
        bus.ifu_rdata_o  = bus.mem_rdata_i;
        bus.lsu_rdata_o  = bus.mem_rdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q <= OWNER_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Bench for jedro_1_mem_arbiter: directed vector table, reset sequences and
// a randomized run scored against a behavioural model with its own memory.
module tb_jedro_1_mem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIM   = 4;
    localparam int WORDS = 64;

    logic clk = 1'b0;
    logic rst;
    logic ram_init;
    always #5 clk = ~clk;

    jedro_1_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    jedro_1_mem_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Memory attached to the arbiter: word i initialised to i, 1-cycle read.
    logic [31:0] ram [WORDS];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < WORDS; i++) ram[i] <= 32'(i);
        end else if (bus.mem_en_o) begin
            bus.mem_rdata_i <= ram[bus.mem_addr_o[7:2]];
            for (int b = 0; b < 4; b++)
                if (bus.mem_we_o[b]) ram[bus.mem_addr_o[7:2]][b*8 +: 8] <= bus.mem_wdata_o[b*8 +: 8];
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
                         input logic [3:0] lbe, input logic [31:0] la, input logic [31:0] ld);
        bus.ifu_req_i   = ir;
        bus.ifu_addr_i  = ia;
        bus.lsu_req_i   = lr;
        bus.lsu_we_i    = lw;
        bus.lsu_be_i    = lbe;
        bus.lsu_addr_i  = la;
        bus.lsu_wdata_i = ld;
    endtask

    typedef struct {
        logic        ir;  logic [31:0] ia;
        logic        lr;  logic        lw; logic [3:0] lbe; logic [31:0] la; logic [31:0] ld;
        logic        e_ig; logic       e_lg; logic [3:0] e_we;
        logic        e_irv; logic      e_lrv; logic      chk_d; logic [31:0] e_d;
    } vec_t;

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
                                input logic [3:0] lbe, input logic [31:0] la, input logic [31:0] ld,
                                input logic e_ig, input logic e_lg, input logic [3:0] e_we,
                                input logic e_irv, input logic e_lrv, input logic chk_d, input logic [31:0] e_d);
        vec_t v;
        v.ir = ir; v.ia = ia; v.lr = lr; v.lw = lw; v.lbe = lbe; v.la = la; v.ld = ld;
        v.e_ig = e_ig; v.e_lg = e_lg; v.e_we = e_we;
        v.e_irv = e_irv; v.e_lrv = e_lrv; v.chk_d = chk_d; v.e_d = e_d;
        return v;
    endfunction

    vec_t tbl[$];
    logic [31:0] model_ram [WORDS];

    initial begin
        // Random-phase variables
        int          waited, pend, w;
        logic [31:0] pend_data;
        logic        ifu_hold, lsu_hold;
        logic        r_ir, r_lr, r_lw;
        logic [31:0] r_ia, r_la, r_ld, merged;
        logic [3:0]  r_be;
        logic [31:0] exp_addr;

        // ROM fetch, byte-merge store/load, owner alternation, starvation
        tbl.push_back(mk(1, 32'h0, 0, 0, 4'h0, 32'h0,  32'h0,        1, 0, 4'h0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 32'h4, 0, 0, 4'h0, 32'h0,  32'h0,        1, 0, 4'h0, 1, 0, 1, 32'd0));
        tbl.push_back(mk(1, 32'h8, 0, 0, 4'h0, 32'h0,  32'h0,        1, 0, 4'h0, 1, 0, 1, 32'd1));
        tbl.push_back(mk(0, 32'h0, 0, 0, 4'h0, 32'h0,  32'h0,        0, 0, 4'h0, 1, 0, 1, 32'd2));
        tbl.push_back(mk(0, 32'h0, 1, 1, 4'hF, 32'h10, 32'h12345678, 0, 1, 4'hF, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0, 1, 1, 4'h3, 32'h10, 32'hDEADBEEF, 0, 1, 4'h3, 0, 1, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0, 1, 0, 4'hF, 32'h10, 32'h0,        0, 1, 4'h0, 0, 1, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0, 0, 0, 4'h0, 32'h0,  32'h0,        0, 0, 4'h0, 0, 1, 1, 32'h1234BEEF));
        tbl.push_back(mk(1, 32'h0, 0, 0, 4'h0, 32'h0,  32'h0,        1, 0, 4'h0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0, 1, 0, 4'h0, 32'h8,  32'h0,        0, 1, 4'h0, 1, 0, 1, 32'd0));
        tbl.push_back(mk(1, 32'h4, 0, 0, 4'h0, 32'h0,  32'h0,        1, 0, 4'h0, 0, 1, 1, 32'd2));
        tbl.push_back(mk(0, 32'h0, 0, 0, 4'h0, 32'h0,  32'h0,        0, 0, 4'h0, 1, 0, 1, 32'd1));
        for (int k = 0; k < 10; k++) begin
            logic gi, prev_i;
            gi     = ((k % 5) == 4);
            prev_i = (k == 5);
            tbl.push_back(mk(1, 32'hC, 1, 0, 4'h0, 32'h14, 32'h0, gi, !gi, 4'h0,
                             prev_i, (k != 0) && !prev_i, (k != 0), prev_i ? 32'd3 : 32'd5));
        end
        tbl.push_back(mk(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 1, 0, 1, 32'd3));

        // Reset state: requests present but nothing granted
        drive(1, 32'h0, 1, 1, 4'hF, 32'h4, 32'hFFFFFFFF);
        rst = 1'b1; ram_init = 1'b1;
        @(negedge clk);
        ram_init = 1'b0;
        @(negedge clk); #1;
        check("rst_ifu_gnt", 32'(bus.ifu_gnt_o), 32'd0);
        check("rst_lsu_gnt", 32'(bus.lsu_gnt_o), 32'd0);
        check("rst_mem_en",  32'(bus.mem_en_o),  32'd0);
        check("rst_mem_we",  32'(bus.mem_we_o),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0); #1;
        check("post_rst_ifu_rv", 32'(bus.ifu_rvalid_o), 32'd0);
        check("post_rst_lsu_rv", 32'(bus.lsu_rvalid_o), 32'd0);

        // Directed vector table
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].ir, tbl[i].ia, tbl[i].lr, tbl[i].lw, tbl[i].lbe, tbl[i].la, tbl[i].ld);
            #1;
            check($sformatf("v%0d_ifu_gnt", i), 32'(bus.ifu_gnt_o), 32'(tbl[i].e_ig));
            check($sformatf("v%0d_lsu_gnt", i), 32'(bus.lsu_gnt_o), 32'(tbl[i].e_lg));
            check($sformatf("v%0d_mem_en", i),  32'(bus.mem_en_o),  32'(tbl[i].e_ig | tbl[i].e_lg));
            check($sformatf("v%0d_mem_we", i),  32'(bus.mem_we_o),  32'(tbl[i].e_we));
            if (tbl[i].e_ig) check($sformatf("v%0d_mem_addr", i), bus.mem_addr_o, tbl[i].ia);
            if (tbl[i].e_lg) check($sformatf("v%0d_mem_addr", i), bus.mem_addr_o, tbl[i].la);
            if (tbl[i].e_lg && tbl[i].lw) check($sformatf("v%0d_mem_wdata", i), bus.mem_wdata_o, tbl[i].ld);
            check($sformatf("v%0d_ifu_rv", i), 32'(bus.ifu_rvalid_o), 32'(tbl[i].e_irv));
            check($sformatf("v%0d_lsu_rv", i), 32'(bus.lsu_rvalid_o), 32'(tbl[i].e_lrv));
            if (tbl[i].chk_d && tbl[i].e_irv) check($sformatf("v%0d_ifu_rdata", i), bus.ifu_rdata_o, tbl[i].e_d);
            if (tbl[i].chk_d && tbl[i].e_lrv) check($sformatf("v%0d_lsu_rdata", i), bus.lsu_rdata_o, tbl[i].e_d);
        end

        // Reset the cycle after an IFU grant: its response must be dropped
        @(negedge clk);
        drive(1, 32'h8, 0, 0, 4'h0, 32'h0, 32'h0); #1;
        check("seqA_ifu_gnt", 32'(bus.ifu_gnt_o), 32'd1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            rst = 1'b1;
            drive(1, 32'h8, 1, 1, 4'hF, 32'h20, 32'hA5A5A5A5); #1;
            check("seqA_rst_ifu_gnt", 32'(bus.ifu_gnt_o), 32'd0);
            check("seqA_rst_lsu_gnt", 32'(bus.lsu_gnt_o), 32'd0);
            check("seqA_rst_mem_en",  32'(bus.mem_en_o),  32'd0);
            check("seqA_rst_mem_we",  32'(bus.mem_we_o),  32'd0);
            check("seqA_rst_ifu_rv",  32'(bus.ifu_rvalid_o), 32'd0);
            check("seqA_rst_lsu_rv",  32'(bus.lsu_rvalid_o), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0); #1;
        check("seqA_rel_ifu_rv", 32'(bus.ifu_rvalid_o), 32'd0);

        // Build up starvation, reset, then expect a full fresh run of LSU grants
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1, 32'hC, 1, 0, 4'h0, 32'h14, 32'h0); #1;
            check("seqB_pre_lsu_gnt", 32'(bus.lsu_gnt_o), 32'd1);
        end
        @(negedge clk);
        rst = 1'b1; #1;
        check("seqB_rst_lsu_gnt", 32'(bus.lsu_gnt_o), 32'd0);
        check("seqB_rst_lsu_rv",  32'(bus.lsu_rvalid_o), 32'd0);
        @(negedge clk);
        rst = 1'b0; #1;
        check("seqB_rel_lsu_rv", 32'(bus.lsu_rvalid_o), 32'd0);
        for (int k = 0; k < 5; k++) begin
            if (k != 0) begin @(negedge clk); #1; end
            check($sformatf("seqB_k%0d_lsu_gnt", k), 32'(bus.lsu_gnt_o), 32'(k < 4));
            check($sformatf("seqB_k%0d_ifu_gnt", k), 32'(bus.ifu_gnt_o), 32'(k == 4));
        end
        // Store attempted during reset must not have reached memory
        @(negedge clk);
        drive(0, 0, 1, 0, 4'h0, 32'h20, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0); #1;
        check("seqB_noreset_write", bus.lsu_rdata_o, 32'd8);

        // Randomized run against the behavioural model
        @(negedge clk);
        rst = 1'b1; ram_init = 1'b1;
        for (int i = 0; i < WORDS; i++) model_ram[i] = 32'(i);
        @(negedge clk);
        ram_init = 1'b0;
        waited = 0; pend = 0; pend_data = '0; ifu_hold = 1'b0; lsu_hold = 1'b0;
        r_ir = 0; r_lr = 0; r_lw = 0; r_ia = 0; r_la = 0; r_ld = 0; r_be = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge clk);
            rst = (cyc == 0) || ($urandom_range(0, 59) == 0);
            if (!ifu_hold) begin
                r_ir = ($urandom_range(0, 3) != 0);
                r_ia = 32'($urandom_range(0, WORDS - 1)) << 2;
            end
            if (!lsu_hold) begin
                r_lr = ($urandom_range(0, 3) != 0);
                r_lw = $urandom_range(0, 1) == 1;
                r_be = 4'($urandom);
                r_la = 32'($urandom_range(0, WORDS - 1)) << 2;
                r_ld = $urandom;
            end
            drive(r_ir, r_ia, r_lr, r_lw, r_be, r_la, r_ld);
            #1;
            // Responses from last cycle's access
            check("rnd_ifu_rv", 32'(bus.ifu_rvalid_o), 32'(!rst && pend == 1));
            check("rnd_lsu_rv", 32'(bus.lsu_rvalid_o), 32'(!rst && pend == 2));
            if (!rst && pend == 1) check("rnd_ifu_rdata", bus.ifu_rdata_o, pend_data);
            if (!rst && pend == 2) check("rnd_lsu_rdata", bus.lsu_rdata_o, pend_data);
            // Who should win: LSU first, unless the IFU has been passed over LIM times
            if (rst)                w = 0;
            else if (r_ir && r_lr)  w = (waited >= LIM) ? 1 : 2;
            else if (r_ir)          w = 1;
            else if (r_lr)          w = 2;
            else                    w = 0;
            check("rnd_ifu_gnt", 32'(bus.ifu_gnt_o), 32'(w == 1));
            check("rnd_lsu_gnt", 32'(bus.lsu_gnt_o), 32'(w == 2));
            check("rnd_mem_en",  32'(bus.mem_en_o),  32'(w != 0));
            check("rnd_mem_we",  32'(bus.mem_we_o),  (w == 2 && r_lw) ? 32'(r_be) : 32'd0);
            if (w != 0) begin
                exp_addr = (w == 1) ? r_ia : r_la;
                check("rnd_mem_addr", bus.mem_addr_o, exp_addr);
                pend_data = model_ram[exp_addr[7:2]];
                if (w == 2 && r_lw) begin
                    merged = pend_data;
                    for (int b = 0; b < 4; b++) if (r_be[b]) merged[b*8 +: 8] = r_ld[b*8 +: 8];
                    model_ram[exp_addr[7:2]] = merged;
                end
            end
            pend     = w;
            waited   = (w == 2 && r_ir) ? ((waited + 1 > LIM) ? LIM : waited + 1) : 0;
            ifu_hold = r_ir && (w != 1) && !rst;
            lsu_hold = r_lr && (w != 2) && !rst;
        end

        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
